// File: rtl/sikep434_ise_sigma_inv.sv
// Multi-cycle inverse of the rv64 sigma linear layer.
// Sigma is L = 1 + t^A + t^B over GF(2)[t]/(t^64+1). Squaring doubles the
// exponents, so L^64 = 1 and L^-1 = L^63 = prod_{i=0..5} L^(2^i). Each
// BUSY cycle applies one pass of sigma with amounts (A<<i, B<<i) mod 64.
`timescale 1ns/1ps

module sikep434_ise_sigma_inv (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] rs1,
  input  logic [4:0]  imm,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rd,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [63:0] acc;
  logic [4:0]  imm_q;
  logic [2:0]  cnt;
  logic        err_q;

  logic [5:0]  base_a;
  logic [5:0]  base_b;
  logic [5:0]  amt_a;
  logic [5:0]  amt_b;
  logic [63:0] rot_a;
  logic [63:0] rot_b;
  logic [63:0] acc_step;

  // Rotate right; an amount of 0 makes the left shift 64, which yields 0,
  // so the result degenerates to the identity as required.
  function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] s);
    return (x >> s) | (x << (7'd64 - {1'b0, s}));
  endfunction

  // Base rotation amounts selected by the captured imm.
  always_comb begin
    base_a = '0;
    base_b = '0;
    case (imm_q)
      5'd0: begin base_a = 6'd19; base_b = 6'd28; end
      5'd1: begin base_a = 6'd61; base_b = 6'd39; end
      5'd2: begin base_a = 6'd1;  base_b = 6'd6;  end
      5'd3: begin base_a = 6'd10; base_b = 6'd17; end
      5'd4: begin base_a = 6'd7;  base_b = 6'd41; end
      default: begin base_a = '0; base_b = '0; end
    endcase
  end

  // Per-step amounts (base << step) mod 64, and one sigma pass on acc.
  always_comb begin
    amt_a    = base_a << cnt;
    amt_b    = base_b << cnt;
    rot_a    = rotr64(acc, amt_a);
    rot_b    = rotr64(acc, amt_b);
    acc_step = acc ^ rot_a ^ rot_b;
  end

  // State register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) state <= S_IDLE;
    else           state <= state_nx;
  end

  // Next-state logic: accept in IDLE, six passes in BUSY, hold in DONE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (req_valid) state_nx = (imm > 5'd4) ? S_DONE : S_BUSY;
      S_BUSY: if (cnt == 3'd5) state_nx = S_DONE;
      S_DONE: if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, apply one step per BUSY cycle.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      acc   <= '0;
      imm_q <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            acc   <= rs1;
            imm_q <= imm;
            cnt   <= '0;
            err_q <= (imm > 5'd4);
          end
        end
        S_BUSY: begin
          acc <= acc_step;
          cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_DONE);
    rsp_err   = (state == S_DONE) && err_q;
    rd        = ((state == S_DONE) && !err_q) ? acc : '0;
  end

endmodule

// File: tb/tb_sikep434_ise_sigma_inv.sv
// Scoreboard bench for the sigma inverse: expected results are queued at
// request acceptance and compared at the response handshake.
`timescale 1ns/1ps

module tb_sikep434_ise_sigma_inv;

  logic        g_clk;
  logic        g_resetn;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] rs1;
  logic [4:0]  imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rd;
  logic        rsp_err;

  sikep434_ise_sigma_inv dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rs1       (rs1),
    .imm       (imm),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rd        (rd),
    .rsp_err   (rsp_err)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [64:0] sb[$];
  logic [63:0] exp_rd_nx  = '0;
  logic        exp_err_nx = 1'b0;
  logic        mon_en     = 1'b0;
  logic        bp_en      = 1'b0;
  int          cyc        = 0;
  int          n_rsp      = 0;

  logic        stall_q   = 1'b0;
  logic [63:0] stall_rd  = '0;
  logic        stall_err = 1'b0;

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned s);
    int unsigned k;
    k = s % 64;
    if (k == 0) return x;
    return (x >> k) | (x << (64 - k));
  endfunction

  function automatic logic [63:0] sigma_fwd(input logic [63:0] x, input logic [4:0] im);
    int unsigned a;
    int unsigned b;
    case (im)
      5'd0: begin a = 19; b = 28; end
      5'd1: begin a = 61; b = 39; end
      5'd2: begin a = 1;  b = 6;  end
      5'd3: begin a = 10; b = 17; end
      default: begin a = 7; b = 41; end
    endcase
    return x ^ rotr(x, a) ^ rotr(x, b);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Random or constant consumer backpressure.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge g_clk);
      #1;
      rsp_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: invariants, stall stability, scoreboard push/pop.
  always @(negedge g_clk) begin
    if (mon_en) begin
      if (!g_resetn) begin
        sb.delete();
        stall_q = 1'b0;
      end else begin
        chk("ready_and_valid", 64'(req_ready & rsp_valid), 64'd0);
        if (!rsp_valid) chk("rd_zero_no_valid", rd, 64'd0);
        if (stall_q) begin
          chk("stall_valid", 64'(rsp_valid), 64'd1);
          chk("stall_rd", rd, stall_rd);
          chk("stall_err", 64'(rsp_err), 64'(stall_err));
        end
        stall_q   = rsp_valid && !rsp_ready;
        stall_rd  = rd;
        stall_err = rsp_err;
        if (req_ready) chk("no_overlap", 64'(sb.size()), 64'd0);
        if (req_valid && req_ready) sb.push_back({exp_err_nx, exp_rd_nx});
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 64'd1, 64'd0);
          end else begin
            logic [64:0] e;
            e = sb.pop_front();
            chk("rd", rd, e[63:0]);
            chk("rsp_err", 64'(rsp_err), 64'(e[64]));
          end
          n_rsp++;
        end
      end
    end
  end

  // Present a request and wait (bounded) until it is accepted.
  task automatic issue(input logic [63:0] v, input logic [4:0] im,
                       input logic [63:0] erd, input logic eerr);
    logic ok;
    ok         = 1'b0;
    req_valid  = 1'b1;
    rs1        = v;
    imm        = im;
    exp_rd_nx  = erd;
    exp_err_nx = eerr;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge g_clk);
      if (req_ready) ok = 1'b1;
    end
    @(posedge g_clk);
    #1;
    req_valid = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  // Count cycles from the accept edge until rsp_valid is seen.
  task automatic wait_rsp(input int exp_lat, input string tag);
    int lat;
    lat = -1;
    for (int n = 1; n <= 300 && lat < 0; n++) begin
      @(negedge g_clk);
      if (rsp_valid) lat = n;
    end
    chk(tag, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    logic [63:0] x;
    logic [4:0]  im;
    int          acc_at[4];
    int          na;
    int          rsp0;

    g_resetn  = 1'b0;
    req_valid = 1'b0;
    rs1       = '0;
    imm       = '0;
    repeat (2) @(posedge g_clk);
    #1;
    mon_en = 1'b1;
    @(negedge g_clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rd", rd, 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    repeat (2) @(posedge g_clk);
    #1;

    // Known vector and latency.
    issue(64'h8400000000000001, 5'd2, 64'h0000000000000001, 1'b0);
    wait_rsp(7, "latency_imm2");

    // All-ones and all-zeros are fixed points for every selector.
    for (int i = 0; i < 5; i++) begin
      issue('1, 5'(i), '1, 1'b0);
      wait_rsp(7, "latency_ones");
      issue('0, 5'(i), '0, 1'b0);
      wait_rsp(7, "latency_zeros");
    end

    // Error selectors then a normal request.
    issue(64'h123, 5'd5, '0, 1'b1);
    wait_rsp(1, "latency_err5");
    issue(64'h123, 5'd31, '0, 1'b1);
    wait_rsp(1, "latency_err31");
    x = rand64();
    issue(sigma_fwd(x, 5'd3), 5'd3, x, 1'b0);
    wait_rsp(7, "latency_after_err");

    // Reset during BUSY cycle 3 discards the in-flight request.
    x = rand64();
    issue(sigma_fwd(x, 5'd1), 5'd1, x, 1'b0);
    @(posedge g_clk);
    #1;
    @(posedge g_clk);
    #1;
    g_resetn = 1'b0;
    @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    @(negedge g_clk);
    chk("midbusy_reset_ready", 64'(req_ready), 64'd1);
    chk("midbusy_reset_valid", 64'(rsp_valid), 64'd0);
    rsp0 = n_rsp;
    repeat (12) @(posedge g_clk);
    #1;
    chk("midbusy_no_rsp", 64'(n_rsp - rsp0), 64'd0);

    // Random round trips through the forward model with backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x  = rand64();
      im = 5'($urandom_range(0, 31));
      if (im > 5'd4) begin
        issue(x, im, '0, 1'b1);
        wait_rsp(1, "latency_rand_err");
      end else begin
        issue(sigma_fwd(x, im), im, x, 1'b0);
        wait_rsp(7, "latency_rand");
      end
    end
    bp_en = 1'b0;
    repeat (12) @(posedge g_clk);
    #1;

    // req_valid held high with rs1 changing every cycle: each result must
    // match the value present at its accept edge, back to back.
    na = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 100 && na < 4; c++) begin
      x          = rand64();
      im         = 5'($urandom_range(0, 4));
      rs1        = sigma_fwd(x, im);
      imm        = im;
      exp_rd_nx  = x;
      exp_err_nx = 1'b0;
      @(negedge g_clk);
      if (req_ready) begin
        acc_at[na] = cyc;
        na++;
      end
      @(posedge g_clk);
      #1;
    end
    req_valid = 1'b0;
    chk("b2b_count", 64'(na), 64'd4);
    for (int i = 1; i < na; i++)
      chk("b2b_interval", 64'(acc_at[i] - acc_at[i-1]), 64'd8);

    repeat (12) @(posedge g_clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
